// File: rtl/vna_capture_seq.sv
// vna_capture_seq: settle-then-accumulate capture sequencer for two signed ADC channels.
// Optional watchdog in CAPTURE is built only when CAPTURE_TIMEOUT_EN is defined.
module vna_capture_seq #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int OUT_WIDTH        = 14,
    parameter int CNT_WIDTH        = 16,
    parameter int ACC_WIDTH        = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        start,
    input  logic                        abort,
    input  logic [CNT_WIDTH-1:0]        cfg_settle,
    input  logic [CNT_WIDTH-1:0]        cfg_samples,
    output logic                        busy,
    output logic                        done,
    output logic                        timeout,
    output logic signed [ACC_WIDTH-1:0] acc_a,
    output logic signed [ACC_WIDTH-1:0] acc_b
);
    localparam int HALF = AXIS_TDATA_WIDTH / 2;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t                       state_q, state_d;
    logic [CNT_WIDTH-1:0]         settle_q, settle_d;
    logic [CNT_WIDTH-1:0]         samples_q, samples_d;
    logic [CNT_WIDTH-1:0]         set_cnt_q, set_cnt_d;
    logic [CNT_WIDTH-1:0]         smp_cnt_q, smp_cnt_d;
    logic signed [ACC_WIDTH-1:0]  acc_a_q, acc_a_d;
    logic signed [ACC_WIDTH-1:0]  acc_b_q, acc_b_d;
    logic signed [OUT_WIDTH-1:0]  a_raw, b_raw;
    logic signed [ACC_WIDTH-1:0]  a_ext, b_ext;
    logic                         start_ok;
    logic                         wd_exp;
    logic                         unused_bits;

    assign a_raw       = s_axis_tdata[OUT_WIDTH-1:0];
    assign b_raw       = s_axis_tdata[HALF+OUT_WIDTH-1:HALF];
    assign a_ext       = ACC_WIDTH'(a_raw);
    assign b_ext       = ACC_WIDTH'(b_raw);
    assign unused_bits = ^{s_axis_tdata[HALF-1:OUT_WIDTH], s_axis_tdata[AXIS_TDATA_WIDTH-1:HALF+OUT_WIDTH]};
    assign start_ok    = (state_q == IDLE) && start && !abort;

    assign busy  = (state_q == SETTLE) || (state_q == CAPTURE);
    assign done  = (state_q == DONE) && !abort;
    assign acc_a = acc_a_q;
    assign acc_b = acc_b_q;

    // State, latched configuration, counters and accumulators
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            samples_q <= '0;
            set_cnt_q <= '0;
            smp_cnt_q <= '0;
            acc_a_q   <= '0;
            acc_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            samples_q <= samples_d;
            set_cnt_q <= set_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            acc_a_q   <= acc_a_d;
            acc_b_q   <= acc_b_d;
        end
    end

    // Next-state logic; abort overrides everything and freezes partial sums
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        samples_d = samples_q;
        set_cnt_d = set_cnt_q;
        smp_cnt_d = smp_cnt_q;
        acc_a_d   = acc_a_q;
        acc_b_d   = acc_b_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    settle_d  = cfg_settle;
                    samples_d = cfg_samples;
                    set_cnt_d = '0;
                    smp_cnt_d = '0;
                    acc_a_d   = '0;
                    acc_b_d   = '0;
                    state_d   = (cfg_settle == '0) ? CAPTURE : SETTLE;
                end
                SETTLE: begin
                    set_cnt_d = set_cnt_q + CNT_WIDTH'(1);
                    if (set_cnt_q == settle_q - CNT_WIDTH'(1)) state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (samples_q == '0) begin
                        state_d = DONE;
                    end else if (s_axis_tvalid) begin
                        acc_a_d   = acc_a_q + a_ext;
                        acc_b_d   = acc_b_q + b_ext;
                        smp_cnt_d = smp_cnt_q + CNT_WIDTH'(1);
                        if (smp_cnt_q + CNT_WIDTH'(1) == samples_q) state_d = DONE;
                    end else if (wd_exp) begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    logic [CNT_WIDTH-1:0] wd_q;
    logic                 timeout_q;

    assign wd_exp  = &wd_q;
    assign timeout = timeout_q;

    // Watchdog counts consecutive CAPTURE cycles without a valid beat
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) wd_q <= '0;
        else          wd_q <= (state_q == CAPTURE && !s_axis_tvalid) ? wd_q + CNT_WIDTH'(1) : '0;
    end

    // Timeout flag is set when the watchdog forces DONE and held until the next start
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)      timeout_q <= 1'b0;
        else if (start_ok) timeout_q <= 1'b0;
        else if (state_q == CAPTURE && state_d == DONE && wd_exp && !s_axis_tvalid) timeout_q <= 1'b1;
    end
`else
    logic unused_start_ok;

    assign wd_exp          = 1'b0;
    assign timeout         = 1'b0;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_vna_capture_seq.sv
// tb_vna_capture_seq: directed self-checking bench for vna_capture_seq (CNT_WIDTH=8).
module tb_vna_capture_seq;
    logic               aclk = 1'b0;
    logic               aresetn = 1'b0;
    logic [31:0]        s_axis_tdata = '0;
    logic               s_axis_tvalid = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [7:0]         cfg_settle = '0;
    logic [7:0]         cfg_samples = '0;
    logic               busy, done, timeout;
    logic signed [31:0] acc_a, acc_b;

    int passed = 0;
    int fails  = 0;
    int total  = 0;
    int busy_cnt, done_cnt;
    logic got;

    vna_capture_seq #(
        .AXIS_TDATA_WIDTH(32), .OUT_WIDTH(14), .CNT_WIDTH(8), .ACC_WIDTH(32)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid), .start(start), .abort(abort),
        .cfg_settle(cfg_settle), .cfg_samples(cfg_samples), .busy(busy),
        .done(done), .timeout(timeout), .acc_a(acc_a), .acc_b(acc_b)
    );

    always #5 aclk = ~aclk;

    function automatic logic [31:0] pk(input int a, input int b);
        return {2'b11, b[13:0], 2'b11, a[13:0]};
    endfunction

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_acc_a", acc_a, 0);
        check("rst_acc_b", acc_b, 0);
        aresetn = 1'b1;
        tick;

        // settle=4, samples=3, tvalid constant; settle-phase beats must be discarded
        cfg_settle = 8'd4; cfg_samples = 8'd3; s_axis_tvalid = 1'b1;
        s_axis_tdata = pk(100, 100); start = 1'b1;
        tick;
        start = 1'b0;
        check("t1_busy_start", busy, 1);
        busy_cnt = int'(busy); done_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            s_axis_tdata = (i <= 4) ? pk(100, 100) : pk(i - 4, 4 - i);
            tick;
            busy_cnt += int'(busy);
            if (i < 7) done_cnt += int'(done);
        end
        check("t1_done", done, 1);
        check("t1_busy_low", busy, 0);
        check("t1_busy_cycles", busy_cnt, 7);
        check("t1_early_done", done_cnt, 0);
        check("t1_acc_a", acc_a, 6);
        check("t1_acc_b", acc_b, -6);
        tick;
        check("t1_done_pulse", done, 0);

        // settle=0, samples=4, tvalid toggling; invalid beats carry junk
        cfg_settle = 8'd0; cfg_samples = 8'd4; s_axis_tvalid = 1'b1;
        s_axis_tdata = pk(1000, 1000); start = 1'b1;
        tick;
        start = 1'b0;
        check("t2_busy", busy, 1);
        done_cnt = 0;
        for (int i = 1; i <= 7; i++) begin
            s_axis_tvalid = (i % 2) == 1;
            s_axis_tdata  = s_axis_tvalid ? pk(32'h3FFF, 32'h2000) : pk(500, 500);
            tick;
            if (i < 7) done_cnt += int'(done);
        end
        check("t2_done", done, 1);
        check("t2_early_done", done_cnt, 0);
        check("t2_acc_a", acc_a, -4);
        check("t2_acc_b", acc_b, -32768);
        tick;

        // settle=0, samples=0: done one cycle after CAPTURE entry with zero sums
        cfg_settle = 8'd0; cfg_samples = 8'd0; s_axis_tvalid = 1'b1;
        s_axis_tdata = pk(9, 9); start = 1'b1;
        tick;
        start = 1'b0;
        check("t3_busy", busy, 1);
        check("t3_no_done_yet", done, 0);
        tick;
        check("t3_done", done, 1);
        check("t3_acc_a", acc_a, 0);
        check("t3_acc_b", acc_b, 0);
        tick;
        check("t3_idle", busy, 0);

        // abort two beats into samples=10, then start+abort together
        cfg_settle = 8'd2; cfg_samples = 8'd10; s_axis_tvalid = 1'b1;
        s_axis_tdata = pk(5, 7); start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        check("t4_partial_a", acc_a, 10);
        check("t4_busy_before", busy, 1);
        abort = 1'b1;
        tick;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_done", done, 0);
        check("t4_hold_a", acc_a, 10);
        check("t4_hold_b", acc_b, 14);
        cfg_settle = 8'd0; cfg_samples = 8'd1; start = 1'b1;
        tick;
        check("t4_sa_busy", busy, 0);
        check("t4_sa_hold_a", acc_a, 10);
        start = 1'b0; abort = 1'b0;
        done_cnt = 0;
        repeat (3) begin
            tick;
            done_cnt += int'(done);
        end
        check("t4_no_done", done_cnt, 0);
        check("t4_still_idle", busy, 0);

        // asynchronous reset mid-CAPTURE, then a normal run
        cfg_settle = 8'd0; cfg_samples = 8'd10; s_axis_tdata = pk(5, 7); start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        check("t5_pre_rst_a", acc_a, 10);
        #1 aresetn = 1'b0;
        #1;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_acc_a", acc_a, 0);
        check("t5_rst_acc_b", acc_b, 0);
        tick;
        #2 aresetn = 1'b1;
        cfg_settle = 8'd1; cfg_samples = 8'd2; s_axis_tdata = pk(-3, 4); start = 1'b1;
        tick;
        start = 1'b0;
        repeat (3) tick;
        check("t5_done", done, 1);
        check("t5_acc_a", acc_a, -6);
        check("t5_acc_b", acc_b, 8);
        tick;

        // source stalls after 2 of 5 beats
        cfg_settle = 8'd0; cfg_samples = 8'd5; s_axis_tvalid = 1'b1;
        s_axis_tdata = pk(2, 3); start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        s_axis_tvalid = 1'b0;
`ifdef CAPTURE_TIMEOUT_EN
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            tick;
            got = done;
        end
        check("t6_wd_done", got, 1);
        check("t6_timeout", timeout, 1);
        check("t6_acc_a", acc_a, 4);
        check("t6_acc_b", acc_b, 6);
        tick;
        check("t6_timeout_sticky", timeout, 1);
        cfg_samples = 8'd1; start = 1'b1;
        tick;
        start = 1'b0;
        check("t6_timeout_clear", timeout, 0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
`else
        done_cnt = 0;
        repeat (300) begin
            tick;
            done_cnt += int'(done);
        end
        check("t6_no_done", done_cnt, 0);
        check("t6_busy_stuck", busy, 1);
        check("t6_timeout_zero", timeout, 0);
        check("t6_acc_a", acc_a, 4);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("t6_abort_idle", busy, 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
